// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU I/O flag unit.
// The default data width and input buffer depth live here, along with the OUTR state encoding.
package cpu_io_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_IN_DEPTH = 4;
    localparam int PTR_W        = $clog2(DEF_IN_DEPTH);

    typedef enum logic [0:0] {
        ST_FREE = 1'b0,
        ST_BUSY = 1'b1
    } outr_state_e;

endpackage

// File: rtl/io_flag_unit_if.sv
// Device and CPU-facing signals of the I/O flag unit, bundled as one interface.
// The slave modport is the unit itself; the master modport is the CPU/device side.
interface io_flag_unit_if #(
    parameter int DATA_W = cpu_io_pkg::DEF_DATA_W
);
    logic [DATA_W-1:0] dev_in_data;
    logic              dev_in_valid;
    logic              dev_in_ready;
    logic [DATA_W-1:0] inpr;
    logic              fgi;
    logic              inp_ack;
    logic              out_load;
    logic [DATA_W-1:0] out_data;
    logic              fgo;
    logic [DATA_W-1:0] dev_out_data;
    logic              dev_out_valid;
    logic              dev_out_ready;
    logic              ion;
    logic              iof;
    logic              int_ack;
    logic              ien;
    logic              irq;
    logic              out_ovf;

    modport slave (
        input  dev_in_data, dev_in_valid, inp_ack, out_load, out_data,
               dev_out_ready, ion, iof, int_ack,
        output dev_in_ready, inpr, fgi, fgo, dev_out_data, dev_out_valid,
               ien, irq, out_ovf
    );

    modport master (
        output dev_in_data, dev_in_valid, inp_ack, out_load, out_data,
               dev_out_ready, ion, iof, int_ack,
        input  dev_in_ready, inpr, fgi, fgo, dev_out_data, dev_out_valid,
               ien, irq, out_ovf
    );
endinterface

// File: rtl/io_sync_fifo.sv
// Input word buffer: synchronous FIFO with a registered count and a zero head when empty.
// Also exports the next-cycle count so the parent can register flags from next-state values.
module io_sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IN_DEPTH = DEF_IN_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(IN_DEPTH):0]     count,
    output logic [$clog2(IN_DEPTH):0]     count_next
);
    localparam int AW = $clog2(IN_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [IN_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_ptr_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(IN_DEPTH));
    assign empty   = (count_q == {CW{1'b0}});
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy next-state; pointers wrap naturally since depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Head word, forced to zero when nothing is buffered.
    always_comb begin
        rdata = {DATA_W{1'b0}};
        if (empty) begin
            rdata = {DATA_W{1'b0}};
        end else begin
            rdata = mem_q[rd_ptr_q];
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/io_flag_unit.sv
// I/O stage of the hardwired CPU: input buffer with FGI, OUTR with FGO, IEN and the interrupt request.
// irq is registered from next-state ien/fgi/fgo so it tracks the flags with no extra cycle of lag.
module io_flag_unit
    import cpu_io_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IN_DEPTH = DEF_IN_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    io_flag_unit_if.slave  bus
);
    localparam int CW = $clog2(IN_DEPTH) + 1;

    logic [DATA_W-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     fifo_count_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_empty_next;
    logic              fifo_push;
    logic              fifo_pop;

    outr_state_e       state_q;
    outr_state_e       state_d;
    logic [DATA_W-1:0] outr_q;
    logic [DATA_W-1:0] outr_d;
    logic              out_ovf_q;
    logic              out_ovf_d;
    logic              ien_q;
    logic              ien_d;
    logic              irq_q;
    logic              irq_d;

    assign fifo_full       = (fifo_count == CW'(IN_DEPTH));
    assign fifo_empty      = (fifo_count == {CW{1'b0}});
    assign fifo_empty_next = (fifo_count_next == {CW{1'b0}});
    assign fifo_push       = bus.dev_in_valid & ~fifo_full;
    assign fifo_pop        = bus.inp_ack & ~fifo_empty;

    io_sync_fifo #(
        .DATA_W   (DATA_W),
        .IN_DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .wdata      (bus.dev_in_data),
        .rdata      (fifo_rdata),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // OUTR handshake, overflow pulse, IEN priority and interrupt request next-state.
    always_comb begin
        state_d   = state_q;
        outr_d    = outr_q;
        out_ovf_d = 1'b0;
        case (state_q)
            ST_FREE: begin
                if (bus.out_load) begin
                    outr_d  = bus.out_data;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_FREE;
                end
            end
            ST_BUSY: begin
                // A load arriving with dev_out_ready is still rejected: fgo was 0 when it was issued.
                out_ovf_d = bus.out_load;
                if (bus.dev_out_ready) begin
                    state_d = ST_FREE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_FREE;
            end
        endcase

        if (bus.iof | bus.int_ack) begin
            ien_d = 1'b0;
        end else if (bus.ion) begin
            ien_d = 1'b1;
        end else begin
            ien_d = ien_q;
        end

        irq_d = ien_d & (~fifo_empty_next | (state_d == ST_FREE));
    end

    // OUTR state machine and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FREE;
            outr_q    <= {DATA_W{1'b0}};
            out_ovf_q <= 1'b0;
            ien_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            outr_q    <= outr_d;
            out_ovf_q <= out_ovf_d;
            ien_q     <= ien_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.dev_in_ready  = ~fifo_full;
    assign bus.inpr          = fifo_rdata;
    assign bus.fgi           = ~fifo_empty;
    assign bus.fgo           = (state_q == ST_FREE);
    assign bus.dev_out_valid = (state_q == ST_BUSY);
    assign bus.dev_out_data  = outr_q;
    assign bus.ien           = ien_q;
    assign bus.irq           = irq_q;
    assign bus.out_ovf       = out_ovf_q;

endmodule

// File: tb/tb_io_flag_unit.sv
// Self-checking bench for io_flag_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the I/O stage.
module tb_io_flag_unit;
    import cpu_io_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    io_flag_unit_if #(.DATA_W(DW)) bus ();

    io_flag_unit #(.DATA_W(DW), .IN_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural model state
    logic [DW-1:0] m_q [$];
    bit            m_busy;
    logic [DW-1:0] m_outr;
    bit            m_ien;
    bit            m_ovf;

    function automatic logic [DW-1:0] m_head();
        if (m_q.size() > 0) return m_q[0];
        return '0;
    endfunction

    // {ready, inpr, fgi, fgo, dout, dvalid, ien, irq, ovf}
    function automatic logic [38:0] exp_vec();
        bit fgi_e;
        bit fgo_e;
        fgi_e = (m_q.size() > 0);
        fgo_e = !m_busy;
        return {(m_q.size() < DEPTH), m_head(), fgi_e, fgo_e, m_outr, m_busy,
                m_ien, (m_ien && (fgi_e || fgo_e)), m_ovf};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {bus.dev_in_ready, bus.inpr, bus.fgi, bus.fgo, bus.dev_out_data,
                bus.dev_out_valid, bus.ien, bus.irq, bus.out_ovf};
    endfunction

    task automatic model_update();
        bit do_pop;
        bit do_push;
        if (rst) begin
            m_q.delete();
            m_busy = 0;
            m_outr = '0;
            m_ien  = 0;
            m_ovf  = 0;
        end else begin
            do_pop  = bus.inp_ack && (m_q.size() > 0);
            do_push = bus.dev_in_valid && (m_q.size() < DEPTH);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(bus.dev_in_data);
            m_ovf = m_busy && bus.out_load;
            if (!m_busy) begin
                if (bus.out_load) begin
                    m_outr = bus.out_data;
                    m_busy = 1;
                end
            end else if (bus.dev_out_ready) begin
                m_busy = 0;
            end
            if (bus.iof || bus.int_ack) m_ien = 0;
            else if (bus.ion) m_ien = 1;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst               = 1'b0;
        bus.dev_in_data   = '0;
        bus.dev_in_valid  = 1'b0;
        bus.inp_ack       = 1'b0;
        bus.out_load      = 1'b0;
        bus.out_data      = '0;
        bus.dev_out_ready = 1'b0;
        bus.ion           = 1'b0;
        bus.iof           = 1'b0;
        bus.int_ack       = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        if ({bus.fgo, bus.fgi, bus.ien, bus.irq, bus.out_ovf} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 10000",
                     {bus.fgo, bus.fgi, bus.ien, bus.irq, bus.out_ovf});
        end
    endtask

    task automatic test_input_basic();
        idle();
        bus.dev_in_valid = 1'b1;
        bus.dev_in_data  = 16'hA5A5;
        step();
        idle();
        checks++;
        if ({bus.fgi, bus.inpr} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL push_a5a5: got fgi=%b inpr=%h expected fgi=1 inpr=a5a5", bus.fgi, bus.inpr);
        end
        bus.inp_ack = 1'b1;
        step();
        idle();
        checks++;
        if ({bus.fgi, bus.inpr} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL pop_last: got fgi=%b inpr=%h expected fgi=0 inpr=0000", bus.fgi, bus.inpr);
        end
        bus.inp_ack = 1'b1;
        step();
        idle();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ack_when_empty: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_fill();
        idle();
        for (int i = 1; i <= 4; i++) begin
            bus.dev_in_valid = 1'b1;
            bus.dev_in_data  = DW'(i);
            step();
        end
        checks++;
        if (bus.dev_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", bus.dev_in_ready);
        end
        bus.dev_in_data = 16'h0005;
        step();
        checks++;
        if ({bus.dev_in_ready, bus.inpr} !== {1'b0, 16'h0001}) begin
            errors++;
            $display("FAIL fifth_held: got ready=%b inpr=%h expected ready=0 inpr=0001",
                     bus.dev_in_ready, bus.inpr);
        end
        bus.inp_ack = 1'b1;
        step();
        idle();
        checks++;
        if ({bus.dev_in_ready, bus.inpr} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL pop_while_full: got ready=%b inpr=%h expected ready=1 inpr=0002",
                     bus.dev_in_ready, bus.inpr);
        end
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (bus.inpr !== DW'(i)) begin
                errors++;
                $display("FAIL drain_order: got %h expected %h", bus.inpr, DW'(i));
            end
            bus.inp_ack = 1'b1;
            step();
            idle();
        end
        checks++;
        if ({bus.fgi, bus.inpr} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL drain_empty: got fgi=%b inpr=%h expected fgi=0 inpr=0000", bus.fgi, bus.inpr);
        end
    endtask

    task automatic test_outr();
        idle();
        bus.out_load = 1'b1;
        bus.out_data = 16'h1234;
        step();
        idle();
        checks++;
        if ({bus.fgo, bus.dev_out_valid, bus.dev_out_data} !== {1'b0, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL outr_load: got fgo=%b valid=%b data=%h expected fgo=0 valid=1 data=1234",
                     bus.fgo, bus.dev_out_valid, bus.dev_out_data);
        end
        bus.out_load = 1'b1;
        bus.out_data = 16'h5678;
        step();
        idle();
        checks++;
        if ({bus.out_ovf, bus.dev_out_data} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL outr_ovf: got ovf=%b data=%h expected ovf=1 data=1234",
                     bus.out_ovf, bus.dev_out_data);
        end
        step();
        checks++;
        if (bus.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pulse: got %b expected 0", bus.out_ovf);
        end
        bus.dev_out_ready = 1'b1;
        bus.out_load      = 1'b1;
        bus.out_data      = 16'h9999;
        step();
        idle();
        checks++;
        if ({bus.fgo, bus.out_ovf, bus.dev_out_data} !== {1'b1, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL load_with_ready: got fgo=%b ovf=%b data=%h expected fgo=1 ovf=1 data=1234",
                     bus.fgo, bus.out_ovf, bus.dev_out_data);
        end
        bus.out_load = 1'b1;
        bus.out_data = 16'hBEEF;
        step();
        idle();
        checks++;
        if ({bus.fgo, bus.out_ovf, bus.dev_out_data} !== {1'b0, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL reload: got fgo=%b ovf=%b data=%h expected fgo=0 ovf=0 data=beef",
                     bus.fgo, bus.out_ovf, bus.dev_out_data);
        end
        bus.dev_out_ready = 1'b1;
        step();
        idle();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL outr_free: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_irq();
        idle();
        bus.out_load = 1'b1;
        bus.out_data = 16'h0101;
        step();
        idle();
        bus.ion = 1'b1;
        step();
        idle();
        checks++;
        if ({bus.ien, bus.irq} !== 2'b10) begin
            errors++;
            $display("FAIL ion_no_flag: got ien=%b irq=%b expected ien=1 irq=0", bus.ien, bus.irq);
        end
        bus.dev_in_valid = 1'b1;
        bus.dev_in_data  = 16'h0077;
        step();
        idle();
        checks++;
        if ({bus.fgi, bus.irq} !== 2'b11) begin
            errors++;
            $display("FAIL irq_on_fgi: got fgi=%b irq=%b expected fgi=1 irq=1", bus.fgi, bus.irq);
        end
        bus.int_ack = 1'b1;
        step();
        idle();
        checks++;
        if ({bus.ien, bus.irq} !== 2'b00) begin
            errors++;
            $display("FAIL int_ack: got ien=%b irq=%b expected ien=0 irq=0", bus.ien, bus.irq);
        end
        bus.ion = 1'b1;
        step();
        idle();
        bus.ion = 1'b1;
        bus.iof = 1'b1;
        step();
        idle();
        checks++;
        if ({bus.ien, bus.irq} !== 2'b00) begin
            errors++;
            $display("FAIL ion_iof: got ien=%b irq=%b expected ien=0 irq=0", bus.ien, bus.irq);
        end
        bus.inp_ack       = 1'b1;
        bus.dev_out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 2; i++) begin
            bus.dev_in_valid = 1'b1;
            bus.dev_in_data  = DW'(16'hC000 + i);
            step();
        end
        idle();
        bus.out_load = 1'b1;
        bus.out_data = 16'h4321;
        bus.ion      = 1'b1;
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dut_vec() !== {1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", dut_vec(),
                     {1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] sent [$];
        logic [DW-1:0] w;
        idle();
        for (int n = 0; n < 10; n++) begin
            w = DW'($urandom);
            sent.push_back(w);
            bus.dev_in_valid = 1'b1;
            bus.dev_in_data  = w;
            step();
            idle();
            for (int g = 0; g < int'($urandom_range(3)); g++) begin
                step();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL wrap_gap: got %h expected %h", dut_vec(), exp_vec());
                end
            end
            w = sent.pop_front();
            checks++;
            if ({bus.fgi, bus.inpr} !== {1'b1, w}) begin
                errors++;
                $display("FAIL wrap_order: got fgi=%b inpr=%h expected fgi=1 inpr=%h", bus.fgi, bus.inpr, w);
            end
            bus.inp_ack = 1'b1;
            step();
            idle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst               = ($urandom_range(99) == 0);
            bus.dev_in_valid  = ($urandom_range(1) == 0);
            bus.dev_in_data   = DW'($urandom);
            bus.inp_ack       = ($urandom_range(4) < 2);
            bus.out_load      = ($urandom_range(9) < 3);
            bus.out_data      = DW'($urandom);
            bus.dev_out_ready = ($urandom_range(4) < 2);
            bus.ion           = ($urandom_range(4) == 0);
            bus.iof           = ($urandom_range(9) == 0);
            bus.int_ack       = ($urandom_range(9) == 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h expected %h", c, dut_vec(), exp_vec());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        m_busy = 0;
        m_outr = '0;
        m_ien  = 0;
        m_ovf  = 0;
        test_reset();
        test_input_basic();
        test_fill();
        test_outr();
        test_irq();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
